// File: rtl/writeback_queue.sv
// Writeback queue: merges load and ALU results into an in-order FIFO that drains
// one register-file write per cycle and tracks which registers still have results in flight.
module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        rf_hold,
   output logic        rf_write_en,
   output logic [4:0]  rf_write_id,
   output logic [31:0] rf_write_data,
   output logic [31:0] pending_mask
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [4:0]    r_rd   [DEPTH];
   logic [31:0]   r_data [DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;

   logic [CW-1:0] w_free;
   logic          w_mem_push, w_alu_push, w_pop, w_head_vld;
   logic [PW-1:0] w_alu_idx;
   logic [31:0]   w_mask;

   // Space comes from the registered count only; a pop this cycle frees nothing yet.
   assign w_free    = CW'(DEPTH) - r_count;
   assign mem_ready = rst | (w_free >= CW'(1));
   assign alu_ready = rst | (w_free >= CW'(2)) | ((w_free >= CW'(1)) & ~mem_valid);

   // x0 results are acknowledged but never occupy a slot.
   assign w_mem_push = ~rst & mem_valid & mem_ready & (mem_rd != 5'd0);
   assign w_alu_push = ~rst & alu_valid & alu_ready & (alu_rd != 5'd0);
   assign w_alu_idx  = r_wptr + PW'(w_mem_push);

   assign w_head_vld    = ~rst & (r_count != '0);
   assign rf_write_en   = w_head_vld & ~rf_hold;
   assign w_pop         = rf_write_en;
   assign rf_write_id   = w_head_vld ? r_rd[r_rptr]   : 5'd0;
   assign rf_write_data = w_head_vld ? r_data[r_rptr] : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + PW'(w_mem_push) + PW'(w_alu_push);
         r_rptr  <= r_rptr + PW'(w_pop);
         r_count <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
      end
   end

   // mem is the older instruction, so it takes the lower slot.
   always_ff @(posedge clk) begin
      if (w_mem_push) begin
         r_rd[r_wptr]   <= mem_rd;
         r_data[r_wptr] <= mem_data;
      end
      if (w_alu_push) begin
         r_rd[w_alu_idx]   <= alu_rd;
         r_data[w_alu_idx] <= alu_data;
      end
   end

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] w_off;
         w_off = PW'(i) - r_rptr;
         if ({1'b0, w_off} < r_count) w_mask[r_rd[i]] = 1'b1;
      end
      w_mask[0] = 1'b0;
   end

   assign pending_mask = rst ? 32'd0 : w_mask;
endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_writeback_queue;
   localparam int DEPTH = 4;

   logic        clk = 0;
   logic        rst;
   logic        mem_valid, alu_valid, rf_hold;
   logic [4:0]  mem_rd, alu_rd;
   logic [31:0] mem_data, alu_data;
   logic        mem_ready, alu_ready, rf_write_en;
   logic [4:0]  rf_write_id;
   logic [31:0] rf_write_data, pending_mask;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;
   ent_t q[$];

   writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .rf_hold(rf_hold), .rf_write_en(rf_write_en), .rf_write_id(rf_write_id),
      .rf_write_data(rf_write_data), .pending_mask(pending_mask)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_in(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic hold);
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      rf_hold = hold;
      #1;
   endtask

   task automatic idle(input logic hold);
      set_in(0, 0, 0, 0, 0, 0, hold);
   endtask

   task automatic test_reset();
      rst = 1;
      set_in(1, 5'd7, 32'h11, 1, 5'd8, 32'h22, 0);
      tick();
      set_in(1, 5'd7, 32'h11, 1, 5'd8, 32'h22, 0);
      n_tests++;
      if ({rf_write_en, rf_write_id, rf_write_data, pending_mask, mem_ready, alu_ready} !==
          {1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_during: en=%b id=%0d data=%h mask=%h mr=%b ar=%b, need 0 0 0 0 1 1",
                  rf_write_en, rf_write_id, rf_write_data, pending_mask, mem_ready, alu_ready);
      end
      tick();
      rst = 0;
      idle(0);
      n_tests++;
      if ({rf_write_en, rf_write_id, rf_write_data, pending_mask, mem_ready, alu_ready} !==
          {1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_after: en=%b id=%0d data=%h mask=%h mr=%b ar=%b, need 0 0 0 0 1 1",
                  rf_write_en, rf_write_id, rf_write_data, pending_mask, mem_ready, alu_ready);
      end
   endtask

   task automatic test_single();
      set_in(0, 0, 0, 1, 5'd5, 32'h1234, 0);
      n_tests++;
      if (alu_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_ready: alu_ready=%b need 1", alu_ready);
      end
      tick();
      idle(0);
      n_tests++;
      if ({rf_write_en, rf_write_id, rf_write_data, pending_mask} !== {1'b1, 5'd5, 32'h1234, 32'h20}) begin
         n_fail++;
         $display("FAIL single_write: en=%b id=%0d data=%h mask=%h, need 1 5 1234 20",
                  rf_write_en, rf_write_id, rf_write_data, pending_mask);
      end
      tick();
      n_tests++;
      if ({rf_write_en, rf_write_id, rf_write_data, pending_mask} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL single_drained: en=%b id=%0d data=%h mask=%h, need 0 0 0 0",
                  rf_write_en, rf_write_id, rf_write_data, pending_mask);
      end
   endtask

   task automatic test_dual();
      set_in(1, 5'd3, 32'hAAAA, 1, 5'd3, 32'hBBBB, 0);
      n_tests++;
      if ({mem_ready, alu_ready} !== 2'b11) begin
         n_fail++; $display("FAIL dual_ready: mr=%b ar=%b need 1 1", mem_ready, alu_ready);
      end
      tick();
      idle(0);
      n_tests++;
      if ({rf_write_en, rf_write_id, rf_write_data, pending_mask} !== {1'b1, 5'd3, 32'hAAAA, 32'h8}) begin
         n_fail++;
         $display("FAIL dual_first: en=%b id=%0d data=%h mask=%h, need 1 3 aaaa 8",
                  rf_write_en, rf_write_id, rf_write_data, pending_mask);
      end
      tick();
      n_tests++;
      if ({rf_write_en, rf_write_id, rf_write_data, pending_mask} !== {1'b1, 5'd3, 32'hBBBB, 32'h8}) begin
         n_fail++;
         $display("FAIL dual_second: en=%b id=%0d data=%h mask=%h, need 1 3 bbbb 8",
                  rf_write_en, rf_write_id, rf_write_data, pending_mask);
      end
      tick();
      n_tests++;
      if ({rf_write_en, pending_mask} !== {1'b0, 32'd0}) begin
         n_fail++; $display("FAIL dual_drained: en=%b mask=%h need 0 0", rf_write_en, pending_mask);
      end
   endtask

   task automatic test_full();
      set_in(1, 5'd1, 32'hD1, 1, 5'd2, 32'hD2, 1);
      tick();
      set_in(1, 5'd3, 32'hD3, 1, 5'd4, 32'hD4, 1);
      tick();
      idle(1);
      n_tests++;
      if ({mem_ready, alu_ready, rf_write_en, pending_mask} !== {1'b0, 1'b0, 1'b0, 32'h1E}) begin
         n_fail++;
         $display("FAIL full_state: mr=%b ar=%b en=%b mask=%h, need 0 0 0 1e",
                  mem_ready, alu_ready, rf_write_en, pending_mask);
      end
      idle(0);
      for (int k = 1; k <= 4; k++) begin
         n_tests++;
         if ({rf_write_en, rf_write_id, rf_write_data} !== {1'b1, 5'(k), 32'hD0 + 32'(k)}) begin
            n_fail++;
            $display("FAIL full_drain%0d: en=%b id=%0d data=%h, need 1 %0d %h",
                     k, rf_write_en, rf_write_id, rf_write_data, k, 32'hD0 + 32'(k));
         end
         tick();
      end
      n_tests++;
      if ({rf_write_en, pending_mask} !== {1'b0, 32'd0}) begin
         n_fail++; $display("FAIL full_empty: en=%b mask=%h need 0 0", rf_write_en, pending_mask);
      end
   endtask

   task automatic test_partial();
      set_in(1, 5'd10, 32'hA0, 1, 5'd11, 32'hA1, 1);
      tick();
      set_in(1, 5'd12, 32'hA2, 0, 0, 0, 1);
      tick();
      set_in(1, 5'd7, 32'hA3, 1, 5'd8, 32'hA4, 1);
      n_tests++;
      if ({mem_ready, alu_ready} !== 2'b10) begin
         n_fail++; $display("FAIL partial_ready: mr=%b ar=%b need 1 0", mem_ready, alu_ready);
      end
      tick();
      idle(1);
      n_tests++;
      if ({pending_mask, mem_ready} !== {32'h1C80, 1'b0}) begin
         n_fail++; $display("FAIL partial_mask: mask=%h mr=%b need 1c80 0", pending_mask, mem_ready);
      end
      idle(0);
      for (int k = 0; k < 4; k++) begin
         logic [4:0] exp_id;
         exp_id = (k == 3) ? 5'd7 : 5'd10 + 5'(k);
         n_tests++;
         if ({rf_write_en, rf_write_id} !== {1'b1, exp_id}) begin
            n_fail++;
            $display("FAIL partial_drain%0d: en=%b id=%0d need 1 %0d", k, rf_write_en, rf_write_id, exp_id);
         end
         tick();
      end
      n_tests++;
      if (rf_write_en !== 1'b0) begin
         n_fail++; $display("FAIL partial_empty: en=%b need 0", rf_write_en);
      end
   endtask

   task automatic test_x0();
      set_in(0, 0, 0, 1, 5'd9, 32'h99, 1);
      tick();
      set_in(0, 0, 0, 1, 5'd0, 32'hDEAD, 1);
      n_tests++;
      if (alu_ready !== 1'b1) begin
         n_fail++; $display("FAIL x0_ready: alu_ready=%b need 1", alu_ready);
      end
      tick();
      idle(1);
      n_tests++;
      if (pending_mask !== 32'h200) begin
         n_fail++; $display("FAIL x0_mask: mask=%h need 200", pending_mask);
      end
      idle(0);
      n_tests++;
      if ({rf_write_en, rf_write_id, rf_write_data} !== {1'b1, 5'd9, 32'h99}) begin
         n_fail++;
         $display("FAIL x0_write: en=%b id=%0d data=%h need 1 9 99", rf_write_en, rf_write_id, rf_write_data);
      end
      tick();
      n_tests++;
      if ({rf_write_en, pending_mask} !== {1'b0, 32'd0}) begin
         n_fail++; $display("FAIL x0_no_extra: en=%b mask=%h need 0 0", rf_write_en, pending_mask);
      end
   endtask

   task automatic test_reset_mid();
      set_in(1, 5'd20, 32'hE0, 1, 5'd21, 32'hE1, 1);
      tick();
      set_in(1, 5'd22, 32'hE2, 0, 0, 0, 1);
      tick();
      rst = 1;
      set_in(1, 5'd23, 32'hE3, 1, 5'd24, 32'hE4, 0);
      tick();
      rst = 0;
      idle(0);
      n_tests++;
      if ({rf_write_en, pending_mask, mem_ready, alu_ready} !== {1'b0, 32'd0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid: en=%b mask=%h mr=%b ar=%b need 0 0 1 1",
                  rf_write_en, pending_mask, mem_ready, alu_ready);
      end
      tick();
      n_tests++;
      if (rf_write_en !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_later: en=%b need 0", rf_write_en);
      end
   endtask

   task automatic test_random();
      q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic        mv, av, hold, e_mr, e_ar, e_en;
         logic [4:0]  mrd, ard, e_id;
         logic [31:0] md, ad, e_data, e_mask;
         int          free;
         mv = ($urandom_range(0, 99) < 60); av = ($urandom_range(0, 99) < 60);
         hold = ($urandom_range(0, 99) < 35);
         mrd = 5'($urandom_range(0, 6)); ard = 5'($urandom_range(0, 6));
         if ($urandom_range(0, 9) == 0) mrd = 5'($urandom_range(0, 31));
         md = $urandom; ad = $urandom;
         set_in(mv, mrd, md, av, ard, ad, hold);

         free   = DEPTH - q.size();
         e_mr   = (free >= 1);
         e_ar   = (free >= 2) || (free >= 1 && !mv);
         e_en   = (q.size() > 0) && !hold;
         e_id   = (q.size() > 0) ? q[0].rd : 5'd0;
         e_data = (q.size() > 0) ? q[0].data : 32'd0;
         e_mask = 32'd0;
         foreach (q[i]) e_mask |= (32'd1 << q[i].rd);
         n_tests++;
         if ({mem_ready, alu_ready, rf_write_en, rf_write_id, rf_write_data, pending_mask} !==
             {e_mr, e_ar, e_en, e_id, e_data, e_mask}) begin
            n_fail++;
            $display("FAIL rand_cyc%0d: mr=%b ar=%b en=%b id=%0d data=%h mask=%h, need %b %b %b %0d %h %h",
                     cyc, mem_ready, alu_ready, rf_write_en, rf_write_id, rf_write_data, pending_mask,
                     e_mr, e_ar, e_en, e_id, e_data, e_mask);
         end
         tick();
         if (e_en) void'(q.pop_front());
         if (mv && e_mr && mrd != 0) q.push_back('{rd: mrd, data: md});
         if (av && e_ar && ard != 0) q.push_back('{rd: ard, data: ad});
      end
   endtask

   initial begin
      rst = 1;
      mem_valid = 0; mem_rd = 0; mem_data = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0; rf_hold = 0;
      @(negedge clk);
      test_reset();
      test_single();
      test_dual();
      test_full();
      test_partial();
      test_x0();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queued write entries (power of two, ≥2).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 mem_valid  input  1  SHALL flag a load-unit result presented this cycle.
REQ-005 mem_rd  input  5  SHALL give the load result's destination register.
REQ-006 mem_data  input  32  SHALL give the load result's value.
REQ-007 mem_ready  output  1  SHALL flag that the load result is accepted this cycle.
REQ-008 alu_valid  input  1  SHALL flag an ALU result presented this cycle.
REQ-009 alu_rd  input  5  SHALL give the ALU result's destination register.
REQ-010 alu_data  input  32  SHALL give the ALU result's value.
REQ-011 alu_ready  output  1  SHALL flag that the ALU result is accepted this cycle.
REQ-012 rf_hold  input  1  SHALL block draining when high.
REQ-013 rf_write_en  output  1  SHALL drive the register-file write enable.
REQ-014 rf_write_id  output  5  SHALL drive the register-file write index.
REQ-015 rf_write_data  output  32  SHALL drive the register-file write data.
REQ-016 pending_mask  output  32  SHALL flag every register with a queued, not-yet-written result.

Function
REQ-017 Internal FIFO of DEPTH entries {rd, data}; count range 0..DEPTH; free = DEPTH - count, using the registered count only (a same-cycle pop SHALL NOT add space).
REQ-018 mem_ready SHALL be 1 iff free ≥ 1.
REQ-019 alu_ready SHALL be 1 iff free ≥ 2, or (free ≥ 1 and mem_valid = 0).
REQ-020 Transfer occurs when valid and ready are both high; ready SHALL NOT depend on the same port's valid.
REQ-021 Same-cycle transfers on both ports SHALL enqueue the mem entry first, then the alu entry (mem is the older instruction).
REQ-022 An accepted transfer with rd = 0 SHALL be acknowledged but SHALL NOT be enqueued, and SHALL consume no FIFO slot.
REQ-023 Enqueued data SHALL be written to the FIFO registers on the accepting clock edge.
REQ-024 rf_write_en SHALL be 1 iff count > 0 and rf_hold = 0; rf_write_id/rf_write_data SHALL equal the head entry (combinational from FIFO registers).
REQ-025 The head SHALL be popped at the edge where rf_write_en = 1; at most one pop per cycle.
REQ-026 Latency: an entry accepted into an empty queue at edge N SHALL appear on rf_write_en in the cycle after N, with rf_hold low.
REQ-027 Enqueue of up to 2 and pop of 1 in the same cycle SHALL be legal; count_next = count + pushes - pop.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 pending_mask bit r SHALL be 1 iff at least one valid FIFO entry has rd = r; bit 0 SHALL always be 0.
REQ-030 Duplicate rd entries SHALL all drain in order; the bit clears only after the last one pops.
REQ-031 When count = 0, rf_write_id and rf_write_data SHALL be 0.

Reset
REQ-032 While rst = 1 at an edge: count, pointers cleared; no transfer is recorded, regardless of valid.
REQ-033 Outputs during and after reset: rf_write_en = 0, rf_write_id = 0, rf_write_data = 0, pending_mask = 0; mem_ready = alu_ready = 1 (queue empty).
REQ-034 Reset mid-operation SHALL discard all queued entries; no write SHALL issue in the cycle following reset.

Verification
REQ-035 Single: alu_valid, rd = 5, data = 0x1234 into an empty queue -> next cycle rf_write_en = 1, id 5, data 0x1234, pending_mask = 0x20; cycle after: mask = 0.
REQ-036 Dual: mem (rd 3, 0xAAAA) and alu (rd 3, 0xBBBB) in the same cycle -> writes to 3 of 0xAAAA then 0xBBBB on consecutive cycles; mask bit 3 stays set until the second write.
REQ-037 Full: rf_hold = 1, push 4 entries -> count 4, mem_ready = alu_ready = 0; release hold -> 4 writes in FIFO order on 4 consecutive cycles.
REQ-038 Partial space: count = 3, both valid -> mem_ready = 1, alu_ready = 0; only the mem entry is enqueued.
REQ-039 x0: alu rd = 0 -> alu_ready = 1, no rf_write_en, count unchanged, mask 0.
REQ-040 Reset mid-run: 3 queued entries, rst for one edge -> rf_write_en = 0 next cycle, pending_mask = 0, ready = 1.
